// File: rtl/seq_datapath_pkg.sv
// Shared encodings for the sequenced datapath: FSM states, command modes,
// ALU operations and B-operand shift codes.
package seq_datapath_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOADA = 3'd1;
  localparam state_t S_LOADB = 3'd2;
  localparam state_t S_EXEC  = 3'd3;
  localparam state_t S_WB    = 3'd4;

  localparam logic [1:0] MODE_RR  = 2'b00;
  localparam logic [1:0] MODE_RI  = 2'b01;
  localparam logic [1:0] MODE_MOV = 2'b10;
  localparam logic [1:0] MODE_CMP = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/seq_datapath_if.sv
// Command/response bundle between the instruction decoder and the datapath,
// plus the debug register-read port.
interface seq_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) ();
  localparam int RW = $clog2(NREGS);

  logic             start;
  logic [1:0]       mode;
  logic [1:0]       aluop;
  logic [1:0]       shift;
  logic [RW-1:0]    rd;
  logic [RW-1:0]    rn;
  logic [RW-1:0]    rm;
  logic [WIDTH-1:0] sximm;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] datapath_out;
  logic [2:0]       status_out;
  logic [RW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, mode, aluop, shift, rd, rn, rm, sximm, dbg_addr,
    input  busy, done, datapath_out, status_out, dbg_data
  );

  modport slave (
    input  start, mode, aluop, shift, rd, rn, rm, sximm, dbg_addr,
    output busy, done, datapath_out, status_out, dbg_data
  );
endinterface

// File: rtl/seq_datapath_regfile.sv
// Register file: one synchronous write port, two asynchronous read ports
// (sequencer operand fetch and debug), cleared by the async reset.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [RW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [RW-1:0]    dbg_addr_i,
  output logic [WIDTH-1:0] dbg_data_o
);
  logic [WIDTH-1:0] mem_q [NREGS];

  // NOTE: this array is reset on purpose (the datapath must read 0 after
  // reset), which keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/seq_datapath.sv
// Datapath with micro-sequencer: one start/done handshake runs a full
// register-transfer operation (fetch A/B, execute, write back).
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         reset,
  seq_datapath_if.slave bus
);
  state_t           state_q, state_d;
  logic [1:0]       mode_q, aluop_q, shift_q;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, c_q;
  logic [2:0]       status_q;

  logic [WIDTH-1:0] rf_rdata, sh_b, ain, bin, alu_res;
  logic [1:0]       alu_op;
  logic             alu_v, accept, rf_we;

  assign accept = (state_q == S_IDLE) && bus.start;
  assign rf_we  = (state_q == S_WB) && (mode_q != MODE_CMP);

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (c_q),
    .raddr_i    ((state_q == S_LOADB) ? rm_q : rn_q),
    .rdata_o    (rf_rdata),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.mode == MODE_MOV) ? S_EXEC : S_LOADA;
      S_LOADA: state_d = (mode_q == MODE_RI) ? S_EXEC : S_LOADB;
      S_LOADB: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_b = b_q;
    case (shift_q)
      SH_LSL1: sh_b = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR1: sh_b = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR1: sh_b = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: sh_b = b_q;
    endcase
  end

  always_comb begin
    ain    = a_q;
    bin    = sh_b;
    alu_op = aluop_q;
    if (mode_q == MODE_RI) begin
      bin = imm_q;
    end else if (mode_q == MODE_MOV) begin
      ain    = '0;
      bin    = imm_q;
      alu_op = OP_ADD;
    end
  end

  // Overflow: operands agree in sign (ADD) or differ (SUB) and the result
  // sign differs from A.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  alu_res = ain & bin;
      OP_MVN:  alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      aluop_q  <= '0;
      shift_q  <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= bus.mode;
        aluop_q <= bus.aluop;
        shift_q <= bus.shift;
        rd_q    <= bus.rd;
        rn_q    <= bus.rn;
        rm_q    <= bus.rm;
        imm_q   <= bus.sximm;
      end
      if (state_q == S_LOADA) a_q <= rf_rdata;
      if (state_q == S_LOADB) b_q <= rf_rdata;
      if (state_q == S_EXEC) begin
        c_q      <= alu_res;
        status_q <= {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
      end
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_WB);
  assign bus.datapath_out = c_q;
  assign bus.status_out   = status_q;
endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench: each accepted command pushes its expected result; a
// monitor pops and compares on every done pulse.
module tb_seq_datapath;
  import seq_datapath_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pushed = 0;
  int   dones  = 0;

  typedef struct {
    logic [15:0] dout;
    logic [2:0]  st;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  seq_datapath_if #(.WIDTH(16), .NREGS(8)) bus ();

  seq_datapath #(.WIDTH(16), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per done pulse, in issue order.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("datapath_out", {16'd0, bus.datapath_out}, {16'd0, e.dout});
        check("status_out", {29'd0, bus.status_out}, {29'd0, e.st});
        check("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] mode, input logic [1:0] op, input logic [1:0] sh,
                       input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [15:0] imm, input logic [15:0] edout, input logic [2:0] est,
                       input int elat, input bit push, input bit wait_for_done);
    exp_t e;
    @(negedge clk);
    check("idle_before_issue", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.aluop = op;
    bus.shift = sh;
    bus.rd    = rd;
    bus.rn    = rn;
    bus.rm    = rm;
    bus.sximm = imm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = 2'bxx;
    bus.rd    = 3'bxxx;
    bus.sximm = 16'hxxxx;
    if (push) begin
      e.dout = edout;
      e.st   = est;
      e.lat  = elat;
      e.acc  = cyc;
      sb.push_back(e);
      pushed++;
    end
    if (wait_for_done) wait_done();
  endtask

  task automatic dbg(input logic [2:0] addr, input logic [15:0] exp, input string name);
    bus.dbg_addr = addr;
    #1;
    check(name, {16'd0, bus.dbg_data}, {16'd0, exp});
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = '0;
    bus.aluop    = '0;
    bus.shift    = '0;
    bus.rd       = '0;
    bus.rn       = '0;
    bus.rm       = '0;
    bus.sximm    = '0;
    bus.dbg_addr = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dout", {16'd0, bus.datapath_out}, 32'd0);
    check("rst_status", {29'd0, bus.status_out}, 32'd0);
    reset = 1'b0;

    // MOV R0,#7
    issue(MODE_MOV, OP_SUB, SH_NONE, 3'd0, 3'd5, 3'd5, 16'h0007, 16'h0007, 3'b000, 2, 1, 1);
    dbg(3'd0, 16'h0007, "dbg_r0");
    // MOV R1,#2 ; ADD R2 = R0 + (R1 LSL1)
    issue(MODE_MOV, OP_ADD, SH_NONE, 3'd1, 3'd0, 3'd0, 16'h0002, 16'h0002, 3'b000, 2, 1, 1);
    issue(MODE_RR,  OP_ADD, SH_LSL1, 3'd2, 3'd0, 3'd1, 16'h0000, 16'h000B, 3'b000, 4, 1, 1);
    dbg(3'd2, 16'h000B, "dbg_r2_add");
    // SUB R5 = 0x7FFF - 0xFFFF overflows
    issue(MODE_MOV, OP_ADD, SH_NONE, 3'd3, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 3'b000, 2, 1, 1);
    issue(MODE_MOV, OP_ADD, SH_NONE, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 3'b010, 2, 1, 1);
    issue(MODE_RR,  OP_SUB, SH_NONE, 3'd5, 3'd3, 3'd4, 16'h0000, 16'h8000, 3'b110, 4, 1, 1);
    dbg(3'd5, 16'h8000, "dbg_r5_sub");
    // CMP R0,R0 with rd=7: no writeback
    issue(MODE_CMP, OP_SUB, SH_NONE, 3'd7, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b001, 4, 1, 1);
    dbg(3'd7, 16'h0000, "dbg_r7_cmp");
    dbg(3'd0, 16'h0007, "dbg_r0_cmp");
    // MOV R6,#0x8000 ; MVN R7 = ~(R6 ASR1)
    issue(MODE_MOV, OP_ADD, SH_NONE, 3'd6, 3'd0, 3'd0, 16'h8000, 16'h8000, 3'b010, 2, 1, 1);
    issue(MODE_RR,  OP_MVN, SH_ASR1, 3'd7, 3'd0, 3'd6, 16'h0000, 16'h3FFF, 3'b000, 4, 1, 1);
    dbg(3'd7, 16'h3FFF, "dbg_r7_mvn");
    // ADD R2 = R6 + (R6 LSR1) = 0xC000
    issue(MODE_RR,  OP_ADD, SH_LSR1, 3'd2, 3'd6, 3'd6, 16'h0000, 16'hC000, 3'b010, 4, 1, 1);
    // SUB R1 = R0 - #8, shift field must not touch the immediate
    issue(MODE_RI,  OP_SUB, SH_LSL1, 3'd1, 3'd0, 3'd3, 16'h0008, 16'hFFFF, 3'b010, 3, 1, 1);
    dbg(3'd1, 16'hFFFF, "dbg_r1_ri");
    // AND R4 = R4 & R3 = 0x7FFF
    issue(MODE_RR,  OP_AND, SH_NONE, 3'd4, 3'd4, 3'd3, 16'h0000, 16'h7FFF, 3'b000, 4, 1, 1);

    // Second start during LOADB must be ignored
    issue(MODE_RR, OP_ADD, SH_NONE, 3'd3, 3'd0, 3'd0, 16'h0000, 16'h000E, 3'b000, 4, 1, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mode  = MODE_MOV;
    bus.rd    = 3'd3;
    bus.sximm = 16'h0055;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    dbg(3'd3, 16'h000E, "dbg_r3_ignored_start");

    // Reset in EXEC aborts the command and clears everything
    issue(MODE_RR, OP_ADD, SH_NONE, 3'd6, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b000, 4, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_dout", {16'd0, bus.datapath_out}, 32'd0);
    check("abort_status", {29'd0, bus.status_out}, 32'd0);
    for (int i = 0; i < 8; i++) dbg(3'(i), 16'h0000, $sformatf("abort_dbg_r%0d", i));
    @(negedge clk);
    reset = 1'b0;
    issue(MODE_MOV, OP_ADD, SH_NONE, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 3'b000, 2, 1, 1);
    dbg(3'd1, 16'h0005, "dbg_r1_after_reset");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("done_count", dones, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Parametrised next-generation CPU datapath with an integrated micro-sequencer.
- Holds a register file, the A/B/C pipeline registers, a shifter, an ALU and a 3-bit status register (Z, N, V).
- Executes one register-transfer operation per start/done handshake, so the top-level FSM issues a single command instead of driving every load and select.
- Sits between the instruction decoder (supplies the command fields) and the memory/IO stage (consumes datapath_out).

Parameters:
- WIDTH, 16, data width of registers, ALU and datapath_out.
- NREGS, 8, register-file depth. Power of two, at least 2. RW = clog2(NREGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request. Sampled only in IDLE.
- mode  in  2  00 ALU reg-reg, 01 ALU reg-imm, 10 MOV imm, 11 CMP.
- aluop  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B).
- shift  in  2  applied to the B operand: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- rd, rn, rm  in  RW each  destination register, A-source register, B-source register.
- sximm  in  WIDTH  sign-extended immediate.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in WB.
- datapath_out  out  WIDTH  C register.
- status_out  out  3  {V, N, Z}.
- dbg_addr  in  RW  debug read address.
- dbg_data  out  WIDTH  combinational read of the register at dbg_addr.

Behaviour:
- Reset (async, any state): state = IDLE; A, B, C, status and all registers = 0; busy = 0; done = 0.
- IDLE, start = 1: latch mode, aluop, shift, rd, rn, rm and sximm into an internal command register. Inputs may change after this edge.
- States: IDLE, LOADA, LOADB, EXEC, WB.
- mode 00/01/11: IDLE -> LOADA -> LOADB -> EXEC -> WB -> IDLE.
- mode 10: IDLE -> EXEC -> WB -> IDLE.
- LOADA: A <= R[rn].
- LOADB: B <= R[rm]. Skipped for mode 01, which goes LOADA -> EXEC.
- EXEC: C <= ALU result; status <= flags. Ain and Bin depend on mode:
  - mode 00 and 11: Ain = A, Bin = shift(B).
  - mode 01: Ain = A, Bin = sximm.
  - mode 10: Ain = 0, Bin = sximm, aluop forced to ADD.
- WB: done = 1. For modes 00/01/10, R[rd] <= C at the edge ending WB. Mode 11 writes nothing.
- Latency from the accepting edge to the done cycle: 4 cycles for modes 00/11, 3 for mode 01, 2 for mode 10.
- Arithmetic is modulo 2^WIDTH.
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/MVN.
- Shifter: LSL1 fills 0 at the LSB. LSR1 fills 0 at the MSB. ASR1 copies the old MSB.
- Reading a register in the same cycle it is written returns the old value. The sequencer never issues such a read.
- start while busy: ignored, no queuing, and the in-flight command is unaffected.
- start held high through WB: a new command is accepted on the first IDLE cycle after WB, so back-to-back commands have a 1-cycle gap.
- datapath_out and status_out hold their values until the next EXEC or reset.

Decomposition:
- Package seq_datapath_pkg: state enum, mode codes, aluop codes, shift codes.
- Sub-module dp_regfile (WIDTH, NREGS):
  - one synchronous write port;
  - two asynchronous read ports (sequencer and debug);
  - asynchronous reset to 0.
- Shifter, ALU and FSM stay inline in seq_datapath.

Test Plan:
- Reset, then MOV R0,#7 (mode 10, sximm = 0x0007) -> done 2 cycles after accept; dbg R0 = 0x0007; datapath_out = 0x0007; status = 000.
- MOV R1,#2, then ADD R2 = R0 + (R1 LSL1) (mode 00, shift 01) -> done after 4 cycles; R2 = 0x000B; status = 000.
- MOV R3,#0x7FFF, MOV R4,#0xFFFF, then SUB R5 = R3 - R4 (mode 00) -> R5 = 0x8000; status V=1, N=1, Z=0.
- CMP R0,R0 (mode 11, SUB) -> Z = 1 and datapath_out = 0. All registers unchanged, including R7 = 0.
- MOV R6,#0x8000, then MVN R7 = ~(R6 ASR1) (mode 00, aluop 11, shift 11) -> R7 = 0x3FFF; status = 000.
- Issue ADD and pulse start again during LOADB -> the second pulse is ignored and only one done pulse appears. Then assert reset during EXEC -> busy = 0, datapath_out = 0, status = 000, every dbg read = 0, and the next command completes normally.
